alarm_set_ctrl: RTL and testbench

Sequencing controller for the alarm-time setting path of the digital clock. It walks the user through hour then minute entry with mode/increment/decrement buttons, keeps a wrap-around edit value, and issues one-cycle parallel-load strobes to the two 6-bit alarm registers (hour and minute). It sits between the debounced button inputs and the `register_6bit` instances' `ld_x`/`input_data` pins. It reads the registers' current `x` outputs back to preload the edit value.

---
 rtl/alarm_pkg.sv | 22 ++
 rtl/alarm_set_ctrl_if.sv | 13 +
 rtl/alarm_set_ctrl_btn_step.sv | 80 ++++++++
 rtl/alarm_set_ctrl.sv | 106 ++++++++++
 tb/tb_alarm_set_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm-time setting controller.
package alarm_pkg;

  typedef logic [0:5] time6_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SET_HR   = 3'd1,
    S_LOAD_HR  = 3'd2,
    S_SET_MIN  = 3'd3,
    S_LOAD_MIN = 3'd4
  } state_t;

  localparam int unsigned HR_MAX_DEF  = 23;
  localparam int unsigned MIN_MAX_DEF = 59;

  // Out-of-range readback (e.g. an uninitialised register) edits from zero.
  function automatic time6_t clamp6(input time6_t v, input time6_t max_v);
    return (v > max_v) ? '0 : v;
  endfunction

endpackage

// File: rtl/alarm_set_ctrl_if.sv
// Register-side bundle: readback of the two alarm registers and their load path.
interface alarm_set_ctrl_if;
  import alarm_pkg::*;

  time6_t cur_hr;
  time6_t cur_min;
  logic   ld_hr;
  logic   ld_min;
  time6_t load_data;

  modport master (input cur_hr, cur_min, output ld_hr, ld_min, load_data);
  modport slave  (output cur_hr, cur_min, input ld_hr, ld_min, load_data);
endinterface

// File: rtl/alarm_set_ctrl_btn_step.sv
// Button edge detector producing a one-cycle step pulse; with
// ALARM_SET_AUTO_REPEAT_EN defined it also generates hold-to-repeat steps.
module btn_step #(
  parameter int unsigned RPT_DLY = 50,
  parameter int unsigned RPT_PER = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  input  logic clr_i,
  output logic step_o
);

  logic btn_q;
  logic arm_q;
  logic edge_w;

  // arm_q blanks the first cycle after reset so a held button is not an edge.
  assign edge_w = btn_i & ~btn_q & arm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
      arm_q <= 1'b1;
    end
  end

`ifdef ALARM_SET_AUTO_REPEAT_EN
  localparam int unsigned CMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DLY_C = CW'(RPT_DLY);
  localparam logic [CW-1:0] PER_C = CW'(RPT_PER);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  // cnt_q holds cycles since the last step/restart; zero means not tracking.
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rpt_q, rpt_d;
  logic          hit;

  always_comb begin
    hit   = btn_i && (cnt_q != '0) && (cnt_q == (rpt_q ? PER_C : DLY_C));
    cnt_d = cnt_q;
    rpt_d = rpt_q;
    if (!btn_i) begin
      cnt_d = '0;
      rpt_d = 1'b0;
    end else if (edge_w || clr_i) begin
      cnt_d = ONE_C;
      rpt_d = 1'b0;
    end else if (hit) begin
      cnt_d = ONE_C;
      rpt_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q + ONE_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rpt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rpt_q <= rpt_d;
    end
  end

  assign step_o = edge_w | hit;
`else
  logic        unused_clr;
  logic [31:0] unused_rpt;
  assign unused_clr = clr_i;
  assign unused_rpt = RPT_DLY ^ RPT_PER;
  assign step_o     = edge_w;
`endif

endmodule

// File: rtl/alarm_set_ctrl.sv
// Alarm hour/minute entry sequencer driving load strobes to the alarm registers.
// Optional hold-to-repeat on inc/dec: define ALARM_SET_AUTO_REPEAT_EN.
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned HR_MAX  = HR_MAX_DEF,
  parameter int unsigned MIN_MAX = MIN_MAX_DEF,
  parameter int unsigned RPT_DLY = 50,
  parameter int unsigned RPT_PER = 10
) (
  input  logic             clk,
  input  logic             alarm_reset,
  input  logic             mode_btn,
  input  logic             inc_btn,
  input  logic             dec_btn,
  alarm_set_ctrl_if.master reg_if,
  output time6_t           edit_val,
  output logic             set_hr,
  output logic             set_min
);

  localparam time6_t HR_M  = time6_t'(HR_MAX);
  localparam time6_t MIN_M = time6_t'(MIN_MAX);

  state_t state_q, state_d;
  time6_t edit_q, edit_d;
  time6_t load_q, load_d;
  time6_t max_v;
  logic   ld_hr_q, ld_min_q, set_hr_q, set_min_q;
  logic   mode_q, arm_q, mode_edge;
  logic   inc_step, dec_step, st_chg;

  assign mode_edge = mode_btn & ~mode_q & arm_q;
  assign st_chg    = (state_d != state_q);

  btn_step #(.RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)) u_inc (
    .clk(clk), .rst_n(alarm_reset), .btn_i(inc_btn), .clr_i(st_chg), .step_o(inc_step)
  );

  btn_step #(.RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)) u_dec (
    .clk(clk), .rst_n(alarm_reset), .btn_i(dec_btn), .clr_i(st_chg), .step_o(dec_step)
  );

  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    max_v   = (state_q == S_SET_MIN) ? MIN_M : HR_M;
    case (state_q)
      S_IDLE: begin
        if (mode_edge) begin
          state_d = S_SET_HR;
          edit_d  = clamp6(reg_if.cur_hr, HR_M);
        end
      end
      S_SET_HR, S_SET_MIN: begin
        if (mode_edge) begin
          state_d = (state_q == S_SET_HR) ? S_LOAD_HR : S_LOAD_MIN;
        end else if (inc_step && !dec_step) begin
          edit_d = (edit_q >= max_v) ? '0 : edit_q + time6_t'(1);
        end else if (dec_step && !inc_step) begin
          edit_d = (edit_q == '0) ? max_v : edit_q - time6_t'(1);
        end
      end
      S_LOAD_HR: begin
        state_d = S_SET_MIN;
        edit_d  = clamp6(reg_if.cur_min, MIN_M);
      end
      S_LOAD_MIN: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    // Mode wins over inc/dec, so edit_d still holds the value to commit here.
    load_d = (state_d == S_LOAD_HR || state_d == S_LOAD_MIN) ? edit_d : '0;
  end

  always_ff @(posedge clk or negedge alarm_reset) begin
    if (!alarm_reset) begin
      state_q   <= S_IDLE;
      edit_q    <= '0;
      load_q    <= '0;
      ld_hr_q   <= 1'b0;
      ld_min_q  <= 1'b0;
      set_hr_q  <= 1'b0;
      set_min_q <= 1'b0;
      mode_q    <= 1'b0;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      edit_q    <= edit_d;
      load_q    <= load_d;
      ld_hr_q   <= (state_d == S_LOAD_HR);
      ld_min_q  <= (state_d == S_LOAD_MIN);
      set_hr_q  <= (state_d == S_SET_HR);
      set_min_q <= (state_d == S_SET_MIN);
      mode_q    <= mode_btn;
      arm_q     <= 1'b1;
    end
  end

  assign reg_if.ld_hr     = ld_hr_q;
  assign reg_if.ld_min    = ld_min_q;
  assign reg_if.load_data = load_q;
  assign edit_val         = edit_q;
  assign set_hr           = set_hr_q;
  assign set_min          = set_min_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Self-checking bench for alarm_set_ctrl: per-cycle compare against a
// spec-level model plus hand-computed literal checkpoints.
module tb_alarm_set_ctrl;

  localparam int HRM = 23;
  localparam int MNM = 59;
  localparam int DLY = 4;
  localparam int PER = 2;
`ifdef ALARM_SET_AUTO_REPEAT_EN
  localparam int REP = 1;
`else
  localparam int REP = 0;
`endif

  logic       clk = 1'b0;
  logic       alarm_reset = 1'b0;
  logic       mode_btn = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0;
  logic [0:5] edit_val;
  logic       set_hr, set_min;

  alarm_set_ctrl_if rif ();

  alarm_set_ctrl #(.HR_MAX(HRM), .MIN_MAX(MNM), .RPT_DLY(DLY), .RPT_PER(PER)) dut (
    .clk(clk), .alarm_reset(alarm_reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .dec_btn(dec_btn), .reg_if(rif.master), .edit_val(edit_val), .set_hr(set_hr),
    .set_min(set_min)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 set hour, 2 load hour, 3 set minute, 4 load minute.
  int m_state = 0, m_edit = 0, m_load = 0;
  bit m_ldhr = 0, m_ldmin = 0;
  bit pm = 0, pi = 0, pd = 0, armed = 0;
  int ci = -1, cd = -1;

  always @(posedge clk or negedge alarm_reset) begin
    if (!alarm_reset) begin
      m_state = 0; m_edit = 0; m_load = 0; m_ldhr = 0; m_ldmin = 0;
      pm = 0; pi = 0; pd = 0; armed = 0; ci = -1; cd = -1;
    end else begin
      bit me, is, ds;
      int ns, ne, mx;
      me = mode_btn && !pm && armed;
      is = 0; ds = 0;
      if (inc_btn && !pi && armed) begin ci = 0; is = 1; end
      else if (!inc_btn) ci = -1;
      else if (ci >= 0) begin
        ci++;
        is = (REP == 1) && ci >= DLY && ((ci - DLY) % PER == 0);
      end
      if (dec_btn && !pd && armed) begin cd = 0; ds = 1; end
      else if (!dec_btn) cd = -1;
      else if (cd >= 0) begin
        cd++;
        ds = (REP == 1) && cd >= DLY && ((cd - DLY) % PER == 0);
      end
      ns = m_state; ne = m_edit;
      case (m_state)
        0: if (me) begin ns = 1; ne = (int'(rif.cur_hr) > HRM) ? 0 : int'(rif.cur_hr); end
        1, 3: begin
          mx = (m_state == 1) ? HRM : MNM;
          if (me) ns = m_state + 1;
          else if (is && !ds) ne = (m_edit + 1) % (mx + 1);
          else if (ds && !is) ne = (m_edit + mx) % (mx + 1);
        end
        2: begin ns = 3; ne = (int'(rif.cur_min) > MNM) ? 0 : int'(rif.cur_min); end
        default: ns = 0;
      endcase
      if (ns != m_state) begin
        if (inc_btn) ci = 0;
        if (dec_btn) cd = 0;
      end
      m_ldhr  = (ns == 2);
      m_ldmin = (ns == 4);
      m_load  = (ns == 2 || ns == 4) ? ne : 0;
      m_state = ns; m_edit = ne;
      pm = mode_btn; pi = inc_btn; pd = dec_btn; armed = 1;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("m_ld_hr", int'(rif.ld_hr), int'(m_ldhr));
      chk("m_ld_min", int'(rif.ld_min), int'(m_ldmin));
      chk("m_load_data", int'(rif.load_data), m_load);
      chk("m_edit_val", int'(edit_val), m_edit);
      chk("m_set_hr", int'(set_hr), int'(m_state == 1));
      chk("m_set_min", int'(set_min), int'(m_state == 3));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // which: 0 mode, 1 inc, 2 dec
  task automatic press(input int which);
    case (which)
      0: mode_btn = 1'b1;
      1: inc_btn  = 1'b1;
      default: dec_btn = 1'b1;
    endcase
    tick(1);
    mode_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
    tick(1);
  endtask

  initial begin
    rif.cur_hr = 6'd0;
    rif.cur_min = 6'd0;
    mode_btn = 1'b1;
    tick(2);
    run = 1;
    chk("rst_edit", int'(edit_val), 0);
    chk("rst_ld", int'(rif.ld_hr) + int'(rif.ld_min), 0);
    alarm_reset = 1'b1;
    tick(3);
    chk("held_thru_rst", int'(set_hr), 0);
    mode_btn = 1'b0;
    tick(1);

    // Basic hour entry and commit
    rif.cur_hr = 6'd7; rif.cur_min = 6'd59;
    press(0);
    chk("enter_hr", int'(edit_val), 7);
    chk("set_hr_flag", int'(set_hr), 1);
    repeat (3) press(1);
    chk("inc3", int'(edit_val), 10);
    mode_btn = 1'b1; tick(1);
    chk("ld_hr_pulse", int'(rif.ld_hr), 1);
    chk("ld_hr_data", int'(rif.load_data), 10);
    mode_btn = 1'b0; tick(1);
    chk("ld_hr_drop", int'(rif.ld_hr), 0);
    chk("min_preload", int'(edit_val), 59);
    press(1);
    chk("min_wrap_up", int'(edit_val), 0);
    press(2);
    chk("min_wrap_dn", int'(edit_val), 59);
    mode_btn = 1'b1; tick(1);
    chk("ld_min_pulse", int'(rif.ld_min), 1);
    chk("ld_min_data", int'(rif.load_data), 59);
    mode_btn = 1'b0; tick(1);
    chk("back_idle", int'(set_min), 0);

    // Hour wrap, simultaneous buttons, clamped minute readback
    rif.cur_hr = 6'd23; rif.cur_min = 6'd62;
    press(0);
    press(1);
    chk("hr_wrap_up", int'(edit_val), 0);
    press(2);
    chk("hr_wrap_dn", int'(edit_val), 23);
    inc_btn = 1'b1; dec_btn = 1'b1; tick(1);
    inc_btn = 1'b0; dec_btn = 1'b0; tick(1);
    chk("inc_dec_same", int'(edit_val), 23);
    mode_btn = 1'b1; inc_btn = 1'b1; tick(1);
    chk("mode_inc_ld", int'(rif.ld_hr), 1);
    chk("mode_inc_data", int'(rif.load_data), 23);
    mode_btn = 1'b0; inc_btn = 1'b0; tick(1);
    chk("min_clamp", int'(edit_val), 0);
    mode_btn = 1'b1; tick(1);
    chk("ld_min_zero", int'(rif.load_data), 0);
    mode_btn = 1'b0; tick(1);

    // Edges in IDLE are dropped, then reset during LOAD_HR
    press(1); press(2);
    rif.cur_hr = 6'd3;
    press(0);
    chk("idle_ignored", int'(edit_val), 3);
    mode_btn = 1'b1; tick(1);
    chk("pre_rst_ld", int'(rif.ld_hr), 1);
    #1 alarm_reset = 1'b0;
    #1 chk("async_drop", int'(rif.ld_hr), 0);
    mode_btn = 1'b0;
    tick(2);
    alarm_reset = 1'b1;
    tick(3);
    chk("post_rst_idle", int'(set_hr) + int'(set_min) + int'(rif.ld_hr) + int'(rif.ld_min), 0);

    // Held increment from 5 for 10 cycles
    rif.cur_hr = 6'd5;
    press(0);
    inc_btn = 1'b1; tick(10);
    inc_btn = 1'b0; tick(1);
    chk("hold_inc", int'(edit_val), (REP == 1) ? 9 : 6);
    press(0); tick(1); press(0); tick(1);

    // Out-of-range hour readback
    rif.cur_hr = 6'd40;
    press(0);
    chk("hr_clamp", int'(edit_val), 0);
    tick(2);

    run = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
